// File: rtl/nn_layer_seq.sv
// Fully-connected layer sequencer: drives input/weight/bias read addresses and nn_mac
// controls per neuron, then hands each result downstream. Optional ReLU: NN_SEQ_RELU_EN.
module nn_layer_seq #(
    parameter int IN_W      = 8,
    parameter int N_W       = 8,
    parameter int WT_ADDR_W = 16,
    parameter int DATA_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [IN_W-1:0]      cfg_num_inputs,
    input  logic [N_W-1:0]       cfg_num_neurons,
    output logic                 busy,
    output logic                 done,
    output logic [IN_W-1:0]      in_addr,
    output logic [WT_ADDR_W-1:0] wt_addr,
    output logic [N_W-1:0]       bias_addr,
    output logic                 mac_clear,
    output logic                 mac_load_bias,
    output logic                 mac_enable,
    input  logic [DATA_W-1:0]    mac_result,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N_W-1:0]       out_addr,
    output logic [DATA_W-1:0]    out_data
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_BIAS = 3'd1,
        S_LOAD = 3'd2,
        S_MAC  = 3'd3,
        S_RES  = 3'd4,
        S_OUT  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t                 state_q, state_d;
    logic [IN_W-1:0]        num_in_q, num_in_d;
    logic [N_W-1:0]         num_neu_q, num_neu_d;
    logic [N_W-1:0]         n_cnt_q, n_cnt_d;
    logic [IN_W-1:0]        i_cnt_q, i_cnt_d;
    logic [WT_ADDR_W-1:0]   wt_ptr_q, wt_ptr_d;
    logic [IN_W-1:0]        in_addr_q, in_addr_d;
    logic [WT_ADDR_W-1:0]   wt_addr_q, wt_addr_d;
    logic [N_W-1:0]         bias_addr_q, bias_addr_d;
    logic [N_W-1:0]         out_addr_q, out_addr_d;
    logic [DATA_W-1:0]      out_data_q, out_data_d;
    logic [IN_W:0]          i_plus1_s, i_plus2_s, num_in_ext_s;

    function automatic logic [DATA_W-1:0] act_f(input logic [DATA_W-1:0] x);
`ifdef NN_SEQ_RELU_EN
        if (x[DATA_W-1]) begin
            return {DATA_W{1'b0}};
        end else begin
            return x;
        end
`else
        return x;
`endif
    endfunction

    // i_cnt is the index of the input being accumulated this MAC cycle
    assign i_plus1_s    = {1'b0, i_cnt_q} + {{IN_W{1'b0}}, 1'b1};
    assign i_plus2_s    = {1'b0, i_cnt_q} + {{(IN_W-1){1'b0}}, 2'b10};
    assign num_in_ext_s = {1'b0, num_in_q};

    // Next-state, counter and address-issue logic
    always_comb begin
        state_d     = state_q;
        num_in_d    = num_in_q;
        num_neu_d   = num_neu_q;
        n_cnt_d     = n_cnt_q;
        i_cnt_d     = i_cnt_q;
        wt_ptr_d    = wt_ptr_q;
        in_addr_d   = in_addr_q;
        wt_addr_d   = wt_addr_q;
        bias_addr_d = bias_addr_q;
        out_addr_d  = out_addr_q;
        out_data_d  = out_data_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        num_in_d  = cfg_num_inputs;
                        num_neu_d = cfg_num_neurons;
                        n_cnt_d   = {N_W{1'b0}};
                        i_cnt_d   = {IN_W{1'b0}};
                        wt_ptr_d  = {WT_ADDR_W{1'b0}};
                        if (cfg_num_neurons == {N_W{1'b0}}) begin
                            state_d = S_DONE;
                        end else begin
                            state_d     = S_BIAS;
                            bias_addr_d = {N_W{1'b0}};
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_BIAS: begin
                    state_d   = S_LOAD;
                    in_addr_d = {IN_W{1'b0}};
                    wt_addr_d = wt_ptr_q;
                    i_cnt_d   = {IN_W{1'b0}};
                    // wt_ptr only advances for weights actually consumed
                    if (num_in_q != {IN_W{1'b0}}) begin
                        wt_ptr_d = wt_ptr_q + {{(WT_ADDR_W-1){1'b0}}, 1'b1};
                    end else begin
                        wt_ptr_d = wt_ptr_q;
                    end
                end
                S_LOAD: begin
                    if (num_in_q == {IN_W{1'b0}}) begin
                        state_d = S_RES;
                    end else begin
                        state_d = S_MAC;
                        if (i_plus1_s < num_in_ext_s) begin
                            in_addr_d = i_plus1_s[IN_W-1:0];
                            wt_addr_d = wt_ptr_q;
                            wt_ptr_d  = wt_ptr_q + {{(WT_ADDR_W-1){1'b0}}, 1'b1};
                        end else begin
                            in_addr_d = in_addr_q;
                        end
                    end
                end
                S_MAC: begin
                    if (i_plus1_s == num_in_ext_s) begin
                        state_d = S_RES;
                    end else begin
                        i_cnt_d = i_plus1_s[IN_W-1:0];
                        if (i_plus2_s < num_in_ext_s) begin
                            in_addr_d = i_plus2_s[IN_W-1:0];
                            wt_addr_d = wt_ptr_q;
                            wt_ptr_d  = wt_ptr_q + {{(WT_ADDR_W-1){1'b0}}, 1'b1};
                        end else begin
                            in_addr_d = in_addr_q;
                        end
                    end
                end
                S_RES: begin
                    state_d    = S_OUT;
                    out_data_d = act_f(mac_result);
                    out_addr_d = n_cnt_q;
                end
                S_OUT: begin
                    if (out_ready) begin
                        if (n_cnt_q == (num_neu_q - {{(N_W-1){1'b0}}, 1'b1})) begin
                            state_d = S_DONE;
                        end else begin
                            n_cnt_d     = n_cnt_q + {{(N_W-1){1'b0}}, 1'b1};
                            bias_addr_d = n_cnt_q + {{(N_W-1){1'b0}}, 1'b1};
                            state_d     = S_BIAS;
                        end
                    end else begin
                        state_d = S_OUT;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, counter, address and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            num_in_q    <= {IN_W{1'b0}};
            num_neu_q   <= {N_W{1'b0}};
            n_cnt_q     <= {N_W{1'b0}};
            i_cnt_q     <= {IN_W{1'b0}};
            wt_ptr_q    <= {WT_ADDR_W{1'b0}};
            in_addr_q   <= {IN_W{1'b0}};
            wt_addr_q   <= {WT_ADDR_W{1'b0}};
            bias_addr_q <= {N_W{1'b0}};
            out_addr_q  <= {N_W{1'b0}};
            out_data_q  <= {DATA_W{1'b0}};
        end else begin
            state_q     <= state_d;
            num_in_q    <= num_in_d;
            num_neu_q   <= num_neu_d;
            n_cnt_q     <= n_cnt_d;
            i_cnt_q     <= i_cnt_d;
            wt_ptr_q    <= wt_ptr_d;
            in_addr_q   <= in_addr_d;
            wt_addr_q   <= wt_addr_d;
            bias_addr_q <= bias_addr_d;
            out_addr_q  <= out_addr_d;
            out_data_q  <= out_data_d;
        end
    end

    assign busy          = (state_q != S_IDLE);
    assign done          = (state_q == S_DONE);
    assign mac_clear     = (state_q == S_IDLE);
    assign mac_load_bias = (state_q == S_LOAD);
    assign mac_enable    = (state_q == S_MAC);
    assign out_valid     = (state_q == S_OUT);
    assign in_addr       = in_addr_q;
    assign wt_addr       = wt_addr_q;
    assign bias_addr     = bias_addr_q;
    assign out_addr      = out_addr_q;
    assign out_data      = out_data_q;

endmodule

// File: doc/nn_layer_seq.md
# nn_layer_seq

Sequencer for one fully-connected layer built around a single `nn_mac` instance. On `start` it walks every neuron of the layer. For each neuron it:
- generates synchronous-read addresses for the input, weight and bias memories;
- drives the MAC's `load_bias` / `enable` / `clear` controls in alignment with memory read data;
- hands each finished neuron result to the downstream activation buffer over a valid/ready handshake.

It sits between the layer-level control (start/done) and the MAC datapath plus its three memories.

## Interface
- `IN_W`, 8: width of input-count and input-address fields (max 2^IN_W−1 inputs).
- `N_W`, 8: width of neuron-count, bias-address and output-address fields.
- `WT_ADDR_W`, 16: weight memory address width; weights stored row-major, neuron by neuron.
- `DATA_W`, 16: fixed-point data width (Q8.8, matches `fixed_t`).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  one-cycle pulse; accepted only in IDLE.
- `abort`  in  1  return to IDLE from any state; no `done`.
- `cfg_num_inputs`  in  IN_W  inputs per neuron, captured on accepted `start`.
- `cfg_num_neurons`  in  N_W  neurons in layer, captured on accepted `start`.
- `busy`  out  1  high from cycle after accepted `start` until `done` cycle inclusive.
- `done`  out  1  one-cycle pulse after last neuron output accepted.
- `in_addr`  out  IN_W  input memory read address.
- `wt_addr`  out  WT_ADDR_W  weight memory read address.
- `bias_addr`  out  N_W  bias memory read address.
- `mac_clear`  out  1  to `nn_mac.clear`.
- `mac_load_bias`  out  1  to `nn_mac.load_bias`.
- `mac_enable`  out  1  to `nn_mac.enable`.
- `mac_result`  in  DATA_W  from `nn_mac.result` (saturated, combinational off accumulator).
- `out_valid`  out  1  neuron result available.
- `out_ready`  in  1  downstream accepts when `out_valid && out_ready`.
- `out_addr`  out  N_W  neuron index of `out_data`.
- `out_data`  out  DATA_W  registered neuron result.

## Operation
- Memories have 1-cycle synchronous read. An address driven in cycle t gives data at the MAC in cycle t+1. Memory data goes directly to the MAC; this block never touches data except `mac_result`.
- Counters:
  - `n_cnt` (neuron) and `i_cnt` (input).
  - `wt_ptr` is reset to 0 on `start` and incremented per weight issued. It is never rewound between neurons, so weight address = n·N_in + i.
- States and per-state behaviour:
  - **IDLE**: `mac_clear`=1. On `start`, capture config and clear counters.
    - If `cfg_num_neurons`=0 → DONE.
    - Otherwise → BIAS.
  - **BIAS**: `bias_addr`=`n_cnt` → LOAD.
  - **LOAD**: `mac_load_bias`=1. Issue `in_addr`=0, `wt_addr`=`wt_ptr`.
    - If N_in=0 → RES.
    - Otherwise → MAC.
  - **MAC**: `mac_enable`=1 every cycle for the data issued in the previous cycle. Issue next address while `i_cnt`+1 < N_in. After N_in enable cycles → RES.
  - **RES**: all MAC controls low; accumulator is final. Register `out_data`←f(`mac_result`) and `out_addr`←`n_cnt` → OUT.
  - **OUT**: `out_valid`=1; `out_data` and `out_addr` held stable until `out_ready`. On handshake:
    - If `n_cnt` = N−1 → DONE.
    - Otherwise increment `n_cnt` → BIAS.
  - **DONE**: `done`=1 for one cycle → IDLE.
- `mac_load_bias` and `mac_enable` are never asserted in the same cycle. `mac_clear` is asserted only in IDLE.
- `start` outside IDLE is ignored. `abort` has priority over every transition and sends the block to IDLE next cycle; no `out_valid` or `done` follows.
- All address outputs are held at their last value when not issuing.

## Timing
- Reset values: state=IDLE, all counters 0, `busy`=0, `done`=0, `out_valid`=0, `out_data`=0, `out_addr`=0, all addresses 0, `mac_load_bias`=`mac_enable`=0. `mac_clear`=1 because IDLE is the reset state.
- Latency: `start` in cycle 0 → first `out_valid` in cycle N_in+4 (BIAS c1, LOAD c2, MAC c3..c(N_in+2), RES c(N_in+3), OUT c(N_in+4)).
- Throughput: N_in+4 cycles per neuron when `out_ready` is held high.
- Back-pressure: stalling in OUT adds exactly one cycle per cycle of `out_ready`=0.
- Reset or `abort` mid-layer: the partial layer is discarded and the next `start` restarts at neuron 0 with `wt_ptr`=0.

## Configuration
- `NN_SEQ_RELU_EN` defined: f(x) = 0 if x is negative (MSB set), else x.
- Undefined: f(x) = x, so signed saturated MAC results pass through unchanged.

## Test plan
- 2 neurons × 3 inputs, inputs {0x0100, 0x0200, 0xFF00}, n0 weights {0x0080, 0x0080, 0x0100}, bias 0x0040 → out (0, 0x00C0) at cycle 7; wt_addr sequence 0..5. n1 weights {0xFF00, 0, 0}, bias 0 → out (1, 0xFF00) without RELU, 0x0000 with RELU; `done` 1 cycle after second handshake.
- `cfg_num_inputs`=0, bias 0x0300, 1 neuron → no `mac_enable` pulses; `out_data`=0x0300 at cycle 4.
- `cfg_num_neurons`=0 → `done` at cycle 1; no `out_valid`, no memory address activity.
- `out_ready` low for 5 cycles on neuron 0 → `out_data`/`out_addr` stable for the whole stall; neuron 1 BIAS starts the cycle after the handshake.
- `abort` during MAC of neuron 1 → IDLE next cycle with `mac_clear`=1, no `done`; a new `start` reproduces scenario 1 results exactly.
- `rst` asserted asynchronously mid-OUT → `out_valid` and `busy` drop immediately; a `start` during OUT (no abort) is ignored.
